video_timing_gen: RTL and testbench

//  Parametrised raster timing generator for the HDMI TX path: produces hsync, vsync, de,

---
 rtl/video_timing_gen.sv | 198 +++++++++++++++++++
 tb/tb_video_timing_gen.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Progressive raster timing generator: run/stop FSM that only stops on a frame boundary, raster counters, registered decode.
// Define VTG_FRAME_CNT_EN to add the 16-bit frame_cnt output.

module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b1,
  parameter logic V_POL    = 1'b1,
  parameter int   CW       = 12
) (
  input  logic          pixel_clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          busy,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  generate
    if (((2 ** CW) <= (H_TOTAL - 1)) || ((2 ** CW) <= (V_TOTAL - 1))) begin : g_cw_too_small
      $error("video_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_r;
  logic [CW-1:0] x_r;
  logic [CW-1:0] y_r;
  logic          stop_pend_r;
  logic          busy_r;
  logic          frame_wrap_s;

  logic          de_s;
  logic          hs_on_s;
  logic          vs_on_s;
  logic          ls_s;
  logic          fs_s;

  logic          de_r;
  logic          hsync_r;
  logic          vsync_r;
  logic          line_start_r;
  logic          frame_start_r;

  assign frame_wrap_s = (state_r == ST_RUN) && (x_r == H_LAST) && (y_r == V_LAST);

  // Run/stop FSM with raster counters; stop_pend mirrors the last en sample taken in RUN
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      x_r         <= CNT_ZERO;
      y_r         <= CNT_ZERO;
      stop_pend_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          x_r         <= CNT_ZERO;
          y_r         <= CNT_ZERO;
          stop_pend_r <= 1'b0;
          if (en) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          stop_pend_r <= ~en;
          if (x_r == H_LAST) begin
            x_r <= CNT_ZERO;
            if (y_r == V_LAST) begin
              y_r <= CNT_ZERO;
              if (stop_pend_r) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end else begin
                state_r <= ST_RUN;
                busy_r  <= 1'b1;
              end
            end else begin
              y_r <= y_r + CNT_ONE;
            end
          end else begin
            x_r <= x_r + CNT_ONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          x_r         <= CNT_ZERO;
          y_r         <= CNT_ZERO;
          stop_pend_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Region decode of the current position; idle positions never decode as active
  always_comb begin
    de_s    = 1'b0;
    hs_on_s = 1'b0;
    vs_on_s = 1'b0;
    ls_s    = 1'b0;
    fs_s    = 1'b0;
    if (state_r == ST_RUN) begin
      de_s    = (x_r < H_ACT) && (y_r < V_ACT);
      hs_on_s = (x_r >= HS_START) && (x_r < HS_END);
      vs_on_s = (y_r >= VS_START) && (y_r < VS_END);
      ls_s    = (x_r == CNT_ZERO);
      fs_s    = (x_r == CNT_ZERO) && (y_r == CNT_ZERO);
    end else begin
      de_s    = 1'b0;
      hs_on_s = 1'b0;
      vs_on_s = 1'b0;
      ls_s    = 1'b0;
      fs_s    = 1'b0;
    end
  end

  // Decode register: outputs trail the counters by one cycle
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      de_r          <= 1'b0;
      hsync_r       <= ~H_POL;
      vsync_r       <= ~V_POL;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      de_r          <= de_s;
      hsync_r       <= hs_on_s ? H_POL : ~H_POL;
      vsync_r       <= vs_on_s ? V_POL : ~V_POL;
      line_start_r  <= ls_s;
      frame_start_r <= fs_s;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;

  // Completed-frame counter; only reset clears it, stop/idle just hold it
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_r <= 16'd0;
    end else if (frame_wrap_s) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

  assign busy        = busy_r;
  assign x           = x_r;
  assign y           = y_r;
  assign de          = de_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default 640x480 instance (u_a) and tiny negative-polarity instance (u_b),
// both checked every sampled cycle against a frame-position reference model.

module tb_video_timing_gen;

  localparam int HA [2] = '{640, 4};
  localparam int HF [2] = '{16, 1};
  localparam int HS [2] = '{96, 1};
  localparam int HB [2] = '{48, 1};
  localparam int VA [2] = '{480, 2};
  localparam int VF [2] = '{10, 1};
  localparam int VS [2] = '{2, 1};
  localparam int VB [2] = '{33, 1};
  localparam bit HP [2] = '{1'b1, 1'b0};
  localparam bit VP [2] = '{1'b1, 1'b0};

  logic pixel_clk = 1'b0;
  logic reset_n   = 1'b1;
  logic en_a      = 1'b0;
  logic en_b      = 1'b0;

  logic        busy_a, de_a, hs_a, vs_a, ls_a, fs_a;
  logic [11:0] x_a, y_a;
  logic        busy_b, de_b, hs_b, vs_b, ls_b, fs_b;
  logic [3:0]  x_b, y_b;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 pixel_clk = ~pixel_clk;

  video_timing_gen u_a (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .en(en_a), .busy(busy_a),
    .x(x_a), .y(y_a), .de(de_a), .hsync(hs_a), .vsync(vs_a),
    .line_start(ls_a), .frame_start(fs_a)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(4)
  ) u_b (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .en(en_b), .busy(busy_b),
    .x(x_b), .y(y_b), .de(de_b), .hsync(hs_b), .vsync(vs_b),
    .line_start(ls_b), .frame_start(fs_b)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  // ---------------- reference model: linear pixel index within the frame ----------------
  function automatic int ht(int k);
    return HA[k] + HF[k] + HS[k] + HB[k];
  endfunction

  function automatic int vt(int k);
    return VA[k] + VF[k] + VS[k] + VB[k];
  endfunction

  function automatic bit in_de(int k, int p);
    return ((p % ht(k)) < HA[k]) && ((p / ht(k)) < VA[k]);
  endfunction

  function automatic bit in_hs(int k, int p);
    return ((p % ht(k)) >= HA[k] + HF[k]) && ((p % ht(k)) < HA[k] + HF[k] + HS[k]);
  endfunction

  function automatic bit in_vs(int k, int p);
    return ((p / ht(k)) >= VA[k] + VF[k]) && ((p / ht(k)) < VA[k] + VF[k] + VS[k]);
  endfunction

  bit m_run [2];
  int m_pos [2];
  bit m_stop [2];
  int m_fc [2];
  bit e_de [2], e_hs [2], e_vs [2], e_ls [2], e_fs [2];

  // Model: frame index advances while running; a stop requested by the previous en sample ends the frame
  always @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_run[k]  <= 1'b0;
        m_pos[k]  <= 0;
        m_stop[k] <= 1'b0;
        m_fc[k]   <= 0;
        e_de[k]   <= 1'b0;
        e_hs[k]   <= !HP[k];
        e_vs[k]   <= !VP[k];
        e_ls[k]   <= 1'b0;
        e_fs[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        e_de[k] <= m_run[k] && in_de(k, m_pos[k]);
        e_hs[k] <= (m_run[k] && in_hs(k, m_pos[k])) ? HP[k] : !HP[k];
        e_vs[k] <= (m_run[k] && in_vs(k, m_pos[k])) ? VP[k] : !VP[k];
        e_ls[k] <= m_run[k] && ((m_pos[k] % ht(k)) == 0);
        e_fs[k] <= m_run[k] && (m_pos[k] == 0);
        if (!m_run[k]) begin
          m_run[k]  <= (k == 0) ? en_a : en_b;
          m_pos[k]  <= 0;
          m_stop[k] <= 1'b0;
        end else begin
          m_stop[k] <= (k == 0) ? !en_a : !en_b;
          if (m_pos[k] == ht(k) * vt(k) - 1) begin
            m_pos[k] <= 0;
            m_fc[k]  <= (m_fc[k] + 1) % 65536;
            if (m_stop[k]) m_run[k] <= 1'b0;
          end else begin
            m_pos[k] <= m_pos[k] + 1;
          end
        end
      end
    end
  end

  function automatic logic [37:0] obs(int k);
    if (k == 0) return {busy_a, 16'(x_a), 16'(y_a), de_a, hs_a, vs_a, ls_a, fs_a};
    return {busy_b, 16'(x_b), 16'(y_b), de_b, hs_b, vs_b, ls_b, fs_b};
  endfunction

  function automatic logic [37:0] expv(int k);
    return {m_run[k], 16'(m_pos[k] % ht(k)), 16'(m_pos[k] / ht(k)),
            e_de[k], e_hs[k], e_vs[k], e_ls[k], e_fs[k]};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    en_a = 1'b0;
    en_b = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge pixel_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== expv(k)) begin
        failures++;
        $display("FAIL reset_state inst=%0d got=%h exp=%h", k, obs(k), expv(k));
      end
    end
    checks++;
    if ({busy_a, x_a, y_a, de_a, hs_a, vs_a, ls_a, fs_a} !== 30'd0) begin
      failures++;
      $display("FAIL reset_default_inactive got=%h exp=0", {busy_a, x_a, y_a, de_a, hs_a, vs_a, ls_a, fs_a});
    end
    checks++;
    if ({hs_b, vs_b, de_b, busy_b} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_negpol_inactive got=%b exp=1100", {hs_b, vs_b, de_b, busy_b});
    end
  endtask

  task automatic test_idle();
    @(negedge pixel_clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge pixel_clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          failures++;
          $display("FAIL idle_hold inst=%0d got=%h exp=%h", k, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_default_lines();
    int de_cnt = 0;
    int hs_cnt = 0;
    en_a = 1'b1;
    for (int i = 0; i < 2410; i++) begin
      @(negedge pixel_clk);
      checks++;
      if (obs(0) !== expv(0)) begin
        failures++;
        $display("FAIL default_raster cyc=%0d got=%h exp=%h", i, obs(0), expv(0));
      end
      if (i == 0) begin
        checks++;
        if ({busy_a, x_a, y_a} !== {1'b1, 12'd0, 12'd0}) begin
          failures++;
          $display("FAIL first_run_cycle got=%b/%0d/%0d exp=1/0/0", busy_a, x_a, y_a);
        end
      end
      if (i == 1) begin
        checks++;
        if ({ls_a, fs_a} !== 2'b11) begin
          failures++;
          $display("FAIL first_strobes got=%b exp=11", {ls_a, fs_a});
        end
      end
      if (i >= 1 && i <= 800) begin
        de_cnt += int'(de_a);
        hs_cnt += int'(hs_a);
      end
    end
    checks++;
    if (de_cnt != 640) begin
      failures++;
      $display("FAIL de_per_line got=%0d exp=640", de_cnt);
    end
    checks++;
    if (hs_cnt != 96) begin
      failures++;
      $display("FAIL hsync_per_line got=%0d exp=96", hs_cnt);
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge pixel_clk);
      checks++;
      if (obs(0) !== expv(0)) begin
        failures++;
        $display("FAIL run_to_300_20 got=%h exp=%h", obs(0), expv(0));
      end
      if (x_a == 12'd300 && y_a == 12'd20) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_300_20 got=timeout exp=position reached");
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, x_a, y_a, de_a, hs_a, vs_a, ls_a, fs_a} !== 30'd0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%h exp=0", {busy_a, x_a, y_a, de_a, hs_a, vs_a, ls_a, fs_a});
    end
    @(negedge pixel_clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge pixel_clk);
      checks++;
      if (obs(0) !== expv(0)) begin
        failures++;
        $display("FAIL restart cyc=%0d got=%h exp=%h", i, obs(0), expv(0));
      end
      if (i == 1) begin
        checks++;
        if ({fs_a, x_a} !== {1'b1, 12'd1}) begin
          failures++;
          $display("FAIL restart_frame_start got=%b/%0d exp=1/1", fs_a, x_a);
        end
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_small_mode();
    int fs_t[$];
    int hs_low = 0;
    int vs_low = 0;
    int de_cnt = 0;
    en_b = 1'b1;
    for (int i = 0; i < 110; i++) begin
      @(negedge pixel_clk);
      checks++;
      if (obs(1) !== expv(1)) begin
        failures++;
        $display("FAIL small_raster cyc=%0d got=%h exp=%h", i, obs(1), expv(1));
      end
      if (fs_b === 1'b1) fs_t.push_back(i);
      if (i >= 1 && i <= 35) begin
        hs_low += int'(hs_b === 1'b0);
        vs_low += int'(vs_b === 1'b0);
        de_cnt += int'(de_b === 1'b1);
      end
    end
    checks++;
    if (hs_low != 5 || vs_low != 7 || de_cnt != 8) begin
      failures++;
      $display("FAIL small_counts got=hs%0d/vs%0d/de%0d exp=hs5/vs7/de8", hs_low, vs_low, de_cnt);
    end
    checks++;
    if (fs_t.size() != 4) begin
      failures++;
      $display("FAIL small_frame_count got=%0d exp=4", fs_t.size());
    end
    for (int j = 1; j < fs_t.size(); j++) begin
      checks++;
      if (fs_t[j] - fs_t[j-1] != 35) begin
        failures++;
        $display("FAIL small_frame_period got=%0d exp=35", fs_t[j] - fs_t[j-1]);
      end
    end
  endtask

  task automatic test_stop();
    bit done = 1'b0;
    logic [3:0] px = 4'd0;
    logic [3:0] py = 4'd0;
    for (int i = 0; i < 100 && y_b != 4'd1; i++) @(negedge pixel_clk);
    en_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pixel_clk);
      checks++;
      if (obs(1) !== expv(1)) begin
        failures++;
        $display("FAIL stop_raster cyc=%0d got=%h exp=%h", i, obs(1), expv(1));
      end
      if (busy_b === 1'b0) begin
        checks++;
        if ({px, py, x_b, y_b, de_b, hs_b, vs_b, ls_b, fs_b} !== {4'd6, 4'd4, 4'd0, 4'd0, 5'b01100}) begin
          failures++;
          $display("FAIL stop_boundary got=%h exp=%h", {px, py, x_b, y_b, de_b, hs_b, vs_b, ls_b, fs_b},
                   {4'd6, 4'd4, 4'd0, 4'd0, 5'b01100});
        end
        done = 1'b1;
        break;
      end
      px = x_b;
      py = y_b;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL stop_timeout got=busy stuck exp=busy fall");
    end
    repeat (3) @(negedge pixel_clk);
    checks++;
    if (obs(1) !== expv(1)) begin
      failures++;
      $display("FAIL stop_idle got=%h exp=%h", obs(1), expv(1));
    end
  endtask

  task automatic test_en_glitch();
    int fs_t[$];
    en_b = 1'b1;
    for (int i = 0; i < 100 && fs_b !== 1'b1; i++) @(negedge pixel_clk);
    fs_t.push_back(-1);
    for (int i = 0; i < 80; i++) begin
      @(negedge pixel_clk);
      checks++;
      if (obs(1) !== expv(1) || busy_b !== 1'b1) begin
        failures++;
        $display("FAIL glitch_run cyc=%0d got=%h exp=%h", i, obs(1), expv(1));
      end
      if (fs_b === 1'b1) fs_t.push_back(i);
      if (i == 5) en_b = 1'b0;
      if (i == 15) en_b = 1'b1;
    end
    checks++;
    if (fs_t.size() != 3) begin
      failures++;
      $display("FAIL glitch_frames got=%0d exp=3", fs_t.size());
    end
    for (int j = 1; j < fs_t.size(); j++) begin
      checks++;
      if (fs_t[j] - fs_t[j-1] != 35) begin
        failures++;
        $display("FAIL glitch_period got=%0d exp=35", fs_t[j] - fs_t[j-1]);
      end
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 3000; i++) begin
      @(negedge pixel_clk);
      checks++;
      if (obs(1) !== expv(1)) begin
        failures++;
        $display("FAIL random_en cyc=%0d got=%h exp=%h", i, obs(1), expv(1));
      end
      if ($urandom_range(0, 7) == 0) en_b = ~en_b;
    end
  endtask

`ifdef VTG_FRAME_CNT_EN
  task automatic test_frame_cnt();
    en_b = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge pixel_clk);
      checks++;
      if (fc_b !== 16'(m_fc[1])) begin
        failures++;
        $display("FAIL frame_cnt got=%0d exp=%0d", fc_b, m_fc[1]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_default_lines();
    test_async_reset();
    test_small_mode();
    test_stop();
    test_en_glitch();
    test_random_en();
`ifdef VTG_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
